uart_frame_sequencer: RTL and testbench

UART_FRAME_SEQUENCER -- requirements
Module: uart_frame_sequencer

---
 rtl/uart_frame_sequencer_if.sv | 24 ++
 rtl/uart_frame_sequencer.sv | 159 +++++++++++++++
 tb/tb_uart_frame_sequencer.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_frame_sequencer_if.sv
// Signal bundle between the frame sequencer and its sample buffer / UART transmitter.
// master = sequencer side, slave = buffer/UART/requester side.
interface uart_frame_sequencer_if;
    logic       start;
    logic [7:0] len;
    logic [7:0] mem_addr;
    logic [7:0] mem_data;
    logic       uart_en;
    logic [7:0] uart_data;
    logic       uart_ready;
    logic       busy;
    logic       done;
    logic       err;

    modport master (
        input  start, len, mem_data, uart_ready,
        output mem_addr, uart_en, uart_data, busy, done, err
    );

    modport slave (
        output start, len, mem_data, uart_ready,
        input  mem_addr, uart_en, uart_data, busy, done, err
    );
endinterface

// File: rtl/uart_frame_sequencer.sv
// Sends HEADER_BYTE, len, mem[0..len-1] to a byte UART with a handshake timeout.
// Define FRAME_CHECKSUM_EN to append an 8-bit additive checksum of len and samples.
//
// state | meaning
// IDLE  | waiting for start
// REQ   | uart_en high, waiting for the UART to start shifting (timeout runs)
// ACK   | UART took the byte, uart_en dropped
// DRAIN | waiting for uart_ready to return high; uart_data frozen
// NEXT  | choose the next byte of the frame
// FETCH | mem_addr presented to the sample buffer
// LOAD  | buffer read latency; mem_data captured into uart_data
// FIN   | one-cycle done pulse
module uart_frame_sequencer #(
    parameter logic [7:0] HEADER_BYTE    = 8'hA5,
    parameter int         TIMEOUT_CYCLES = 8191
) (
    input  logic                   clk,
    input  logic                   rst,
    uart_frame_sequencer_if.master seq_io
);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {IDLE, LOAD, FETCH, REQ, ACK, DRAIN, NEXT, FIN} state_t;
    typedef enum logic [1:0] {PH_HDR, PH_LEN, PH_SAMP, PH_CSUM} phase_t;

    state_t        state_q, state_d;
    phase_t        phase_q, phase_d;
    logic [7:0]    len_q, len_d;
    logic [7:0]    addr_q, addr_d;
    logic [7:0]    data_q, data_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          err_q, err_d;
    logic          last_byte;
`ifdef FRAME_CHECKSUM_EN
    logic [7:0]    csum_q, csum_d;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            phase_q <= PH_HDR;
            len_q   <= 8'h00;
            addr_q  <= 8'h00;
            data_q  <= 8'h00;
            tmo_q   <= '0;
            err_q   <= 1'b0;
`ifdef FRAME_CHECKSUM_EN
            csum_q  <= 8'h00;
`endif
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            len_q   <= len_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            tmo_q   <= tmo_d;
            err_q   <= err_d;
`ifdef FRAME_CHECKSUM_EN
            csum_q  <= csum_d;
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        phase_d   = phase_q;
        len_d     = len_q;
        addr_d    = addr_q;
        data_d    = data_q;
        tmo_d     = '0;
        err_d     = 1'b0;
        last_byte = 1'b0;
`ifdef FRAME_CHECKSUM_EN
        csum_d    = csum_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (seq_io.start) begin
                    len_d   = seq_io.len;
                    phase_d = PH_HDR;
                    data_d  = HEADER_BYTE;
                    state_d = REQ;
`ifdef FRAME_CHECKSUM_EN
                    csum_d  = 8'h00;
`endif
                end
            end
            REQ: begin
                tmo_d = tmo_q + TW'(1);
                if (!seq_io.uart_ready) begin
                    state_d = ACK;
                end else if (tmo_q == TMO_LAST) begin
                    state_d = IDLE;
                    err_d   = 1'b1;
                end
            end
            ACK:   state_d = DRAIN;
            DRAIN: if (seq_io.uart_ready) state_d = NEXT;
            NEXT: begin
                unique case (phase_q)
                    PH_HDR: begin
                        data_d  = len_q;
                        phase_d = PH_LEN;
                        state_d = REQ;
`ifdef FRAME_CHECKSUM_EN
                        csum_d  = csum_q + len_q;
`endif
                    end
                    PH_LEN: begin
                        if (len_q != 8'h00) begin
                            addr_d  = 8'h00;
                            phase_d = PH_SAMP;
                            state_d = FETCH;
                        end else begin
                            last_byte = 1'b1;
                        end
                    end
                    PH_SAMP: begin
                        // mem_addr doubles as the sample index; stops at len-1 so 255 never wraps
                        if (addr_q != len_q - 8'd1) begin
                            addr_d  = addr_q + 8'd1;
                            state_d = FETCH;
                        end else begin
                            last_byte = 1'b1;
                        end
                    end
                    default: state_d = FIN;
                endcase
                if (last_byte) begin
`ifdef FRAME_CHECKSUM_EN
                    data_d  = csum_q;
                    phase_d = PH_CSUM;
                    state_d = REQ;
`else
                    state_d = FIN;
`endif
                end
            end
            FETCH: state_d = LOAD;
            LOAD: begin
                data_d  = seq_io.mem_data;
                state_d = REQ;
`ifdef FRAME_CHECKSUM_EN
                csum_d  = csum_q + seq_io.mem_data;
`endif
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign seq_io.uart_en   = (state_q == REQ);
    assign seq_io.uart_data = data_q;
    assign seq_io.mem_addr  = addr_q;
    assign seq_io.busy      = (state_q != IDLE) && (state_q != FIN);
    assign seq_io.done      = (state_q == FIN);
    assign seq_io.err       = err_q;
endmodule

// File: tb/tb_uart_frame_sequencer.sv
// Scoreboard bench for uart_frame_sequencer: expected UART bytes are queued at start,
// a negedge monitor pops and compares each fresh uart_en request.
module tb_uart_frame_sequencer;
    localparam int TMO   = 40;
    localparam int SHIFT = 4;
`ifdef FRAME_CHECKSUM_EN
    localparam int CS = 1;
`else
    localparam int CS = 0;
`endif

    typedef struct {
        logic [7:0] data;
        int         gap;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    uart_frame_sequencer_if bus ();

    uart_frame_sequencer #(.HEADER_BYTE(8'hA5), .TIMEOUT_CYCLES(TMO)) dut (
        .clk    (clk),
        .rst    (rst),
        .seq_io (bus)
    );

    always #5 clk = ~clk;

    exp_t       sb[$];
    exp_t       mon_e;
    logic [7:0] mem [256];
    int         n_vec = 0;
    int         n_err = 0;
    int         bytes_seen = 0;
    int         done_seen = 0;
    logic [7:0] last_tx = 8'h00;
    bit         stuck = 0;
    bit         abort = 0;
    logic [7:0] shift_byte;
    logic [7:0] addr_d1 = 8'h00;
    logic       en_prev = 1'b0;
    logic       rdy_prev = 1'b1;
    int         gap = 0;

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // sample buffer: data for an address appears one cycle after it is presented
    initial begin
        bus.mem_data = 8'h00;
        forever begin
            @(negedge clk);
            bus.mem_data = mem[addr_d1];
            addr_d1      = bus.mem_addr;
        end
    end

    // UART model: takes a byte on uart_en, shifts for SHIFT cycles, data must stay put
    initial begin
        bus.uart_ready = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            if (bus.uart_en && bus.uart_ready && !stuck && !rst) begin
                shift_byte     = bus.uart_data;
                bus.uart_ready = 1'b0;
                repeat (SHIFT) @(posedge clk);
                #2;
                if (!abort) check("data_hold", bus.uart_data, shift_byte);
                bus.uart_ready = 1'b1;
            end
        end
    end

    // monitor
    initial begin
        forever begin
            @(negedge clk);
            if (bus.uart_ready && !rdy_prev) gap = 0;
            else gap++;
            if (bus.done) done_seen++;
            if (bus.uart_en && !en_prev) begin
                bytes_seen++;
                last_tx = bus.uart_data;
                if (sb.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_byte: got %02h, expected no byte", bus.uart_data);
                end else begin
                    mon_e = sb.pop_front();
                    check("uart_byte", bus.uart_data, mon_e.data);
                    if (mon_e.gap >= 0) check("byte_latency", gap, mon_e.gap);
                end
            end
            en_prev  = bus.uart_en;
            rdy_prev = bus.uart_ready;
        end
    end

    task automatic push_frame(input int L);
        exp_t e;
`ifdef FRAME_CHECKSUM_EN
        logic [7:0] cs;
        cs = 8'(L);
`endif
        e.data = 8'hA5; e.gap = -1; sb.push_back(e);
        e.data = 8'(L); e.gap = 2;  sb.push_back(e);
        for (int i = 0; i < L; i++) begin
            e.data = mem[i]; e.gap = 4; sb.push_back(e);
`ifdef FRAME_CHECKSUM_EN
            cs = cs + mem[i];
`endif
        end
`ifdef FRAME_CHECKSUM_EN
        e.data = cs; e.gap = 2; sb.push_back(e);
`endif
    endtask

    task automatic send_start(input int L);
        @(negedge clk);
        bus.start = 1'b1;
        bus.len   = 8'(L);
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic run_frame(input int L, input int retrig_byte, input int exp_last);
        int b0, d0;
        bit busy_ok, addr_ok, got_done, hit;
        b0 = bytes_seen; d0 = done_seen;
        busy_ok = 1; addr_ok = 1; got_done = 0; hit = 0;
        push_frame(L);
        send_start(L);
        for (int cyc = 0; cyc < 20000; cyc++) begin
            if (bus.done) begin
                got_done = 1;
                break;
            end
            if (!bus.busy) busy_ok = 0;
            if (L == 0 && bus.mem_addr != 8'h00) addr_ok = 0;
            if (retrig_byte > 0 && !hit && bytes_seen - b0 == retrig_byte) begin
                hit = 1;
                bus.start = 1'b1;
                bus.len   = 8'd9;
                @(negedge clk);
                bus.start = 1'b0;
            end else begin
                @(negedge clk);
            end
        end
        check("done_reached", got_done, 1);
        check("busy_during_frame", busy_ok, 1);
        check("busy_at_done", bus.busy, 0);
        if (L == 0) check("mem_addr_len0", addr_ok, 1);
        if (retrig_byte > 0) check("retrig_issued", hit, 1);
        repeat (12) @(negedge clk);
        check("done_count", done_seen - d0, 1);
        check("byte_count", bytes_seen - b0, L + 2 + CS);
        check("scoreboard_empty", sb.size(), 0);
        check("last_byte", last_tx, exp_last);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_uart_en"}, bus.uart_en, 0);
        check({tag, "_uart_data"}, bus.uart_data, 0);
        check({tag, "_mem_addr"}, bus.mem_addr, 0);
        check({tag, "_busy"}, bus.busy, 0);
        check({tag, "_done"}, bus.done, 0);
        check({tag, "_err"}, bus.err, 0);
    endtask

    initial begin
        int b0, d0, cnt;
        bit hit;
        bus.start = 1'b0;
        bus.len   = 8'h00;
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;

        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // len=0 right after reset: mem_addr must never move
        run_frame(0, 0, 8'h00);

        mem[0] = 8'h11; mem[1] = 8'h22; mem[2] = 8'h33;
        run_frame(3, 0, (CS != 0) ? 8'h69 : 8'h33);

        // checksum wraps: 02+FF+02 = 103
        mem[0] = 8'hFF; mem[1] = 8'h02;
        run_frame(2, 0, (CS != 0) ? 8'h03 : 8'h02);

        // start during sample byte 1 is ignored
        mem[0] = 8'h01; mem[1] = 8'h02; mem[2] = 8'h03; mem[3] = 8'h04;
        run_frame(4, 4, (CS != 0) ? 8'h0E : 8'h04);

        // timeout: UART never leaves idle
        stuck = 1; d0 = done_seen; cnt = 0; hit = 0;
        mon_e.data = 8'hA5; mon_e.gap = -1; sb.push_back(mon_e);
        send_start(2);
        for (int cyc = 0; cyc < 1000; cyc++) begin
            if (bus.err) begin
                hit = 1;
                break;
            end
            if (bus.uart_en) cnt++;
            @(negedge clk);
        end
        check("timeout_err_seen", hit, 1);
        check("timeout_en_cycles", cnt, TMO);
        check("timeout_uart_en", bus.uart_en, 0);
        check("timeout_busy", bus.busy, 0);
        @(negedge clk);
        check("timeout_err_pulse", bus.err, 0);
        repeat (5) @(negedge clk);
        check("timeout_no_done", done_seen - d0, 0);
        check("timeout_sb_empty", sb.size(), 0);
        stuck = 0;

        // reset while sample byte 2 is shifting
        mem[0] = 8'h10; mem[1] = 8'h20; mem[2] = 8'h30; mem[3] = 8'h40;
        b0 = bytes_seen; hit = 0;
        push_frame(4);
        send_start(4);
        for (int cyc = 0; cyc < 2000; cyc++) begin
            if (bytes_seen - b0 == 5 && !bus.uart_ready) begin
                hit = 1;
                break;
            end
            @(negedge clk);
        end
        check("midframe_reached", hit, 1);
        abort = 1;
        rst   = 1'b1;
        @(negedge clk);
        check_reset_outputs("midframe_reset");
        rst = 1'b0;
        sb.delete();
        for (int cyc = 0; cyc < 100 && !bus.uart_ready; cyc++) @(negedge clk);
        @(negedge clk);
        abort = 0;
        check("after_reset_idle", bus.busy, 0);
        mem[0] = 8'h5A;
        run_frame(1, 0, (CS != 0) ? 8'h5B : 8'h5A);

        // len=255, mem[i]=i
        for (int i = 0; i < 256; i++) mem[i] = 8'(i);
        run_frame(255, 0, (CS != 0) ? 8'h80 : 8'hFE);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
